mul_seq: RTL and testbench

Multi-cycle 32×32→64 integer multiplier, the multiplicative counterpart of the team's sequential divider. It shares the divider's `enable`/`completed` handshake and `src`/`sink` operand naming, so the execute stage can drive both units the same way. The unit covers RV32M MUL/MULH/MULHSU/MULHU: the core selects `lo` or `hi` from the 64-bit product. It is radix-2 shift-add with sign pre/post-correction: 32 iterations plus one correction cycle.

---
 rtl/mul_seq.sv | 83 ++++++++
 tb/tb_mul_seq.sv | 176 +++++++++++++++++
 2 files changed

// File: rtl/mul_seq.sv
// Sequential 32x32->64 radix-2 shift-add multiplier with sign pre/post-correction.
// Shares the sequential divider's enable/completed handshake; covers RV32M MUL/MULH/MULHSU/MULHU.
module mul_seq (
  input  logic        clk,
  input  logic        rstn,
  input  logic        enable,
  input  logic [1:0]  mode,
  input  logic [31:0] src,
  input  logic [31:0] sink,
  output logic        completed,
  output logic [31:0] lo,
  output logic [31:0] hi
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_BUSY,
    S_FIX,
    S_DONE
  } state_t;

  state_t      r_state;
  logic [31:0] r_mcand;
  logic [31:0] r_mplier;
  logic [63:0] r_acc;
  logic [5:0]  r_cnt;
  logic        r_neg;

  logic        w_src_neg;
  logic        w_sink_neg;
  logic [32:0] w_sum;
  logic [63:0] w_result;

  always_comb begin
    // Mode 11 is reserved and falls through to the unsigned case.
    w_src_neg  = ((mode == 2'b01) || (mode == 2'b10)) && src[31];
    w_sink_neg = (mode == 2'b01) && sink[31];
    w_sum      = {1'b0, r_acc[63:32]} + (r_mplier[0] ? {1'b0, r_mcand} : 33'd0);
    w_result   = r_neg ? (~r_acc + 64'd1) : r_acc;
  end

  // NOTE: the operand/accumulator datapath is deliberately left out of reset;
  // it is always reloaded on accept and never observed before that.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      r_state   <= S_IDLE;
      r_cnt     <= 6'd0;
      completed <= 1'b0;
      lo        <= 32'd0;
      hi        <= 32'd0;
    end else begin
      case (r_state)
        S_IDLE, S_DONE: begin
          if (enable) begin
            r_mcand   <= w_src_neg  ? (~src + 32'd1)  : src;
            r_mplier  <= w_sink_neg ? (~sink + 32'd1) : sink;
            r_neg     <= w_src_neg ^ w_sink_neg;
            r_acc     <= 64'd0;
            r_cnt     <= 6'd0;
            completed <= 1'b0;
            r_state   <= S_BUSY;
          end
        end
        S_BUSY: begin
          // Carry out of the upper-half add shifts back in as the new MSB.
          r_acc    <= {w_sum, r_acc[31:1]};
          r_mplier <= r_mplier >> 1;
          r_cnt    <= r_cnt + 6'd1;
          if (r_cnt == 6'd31) begin
            r_state <= S_FIX;
          end
        end
        S_FIX: begin
          {hi, lo}  <= w_result;
          completed <= 1'b1;
          r_state   <= S_DONE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mul_seq.sv
// Self-checking bench for mul_seq: cycle-level reference model plus directed
// vectors with hand-computed products, including busy-ignore and mid-operation reset.
module tb_mul_seq;

  logic        clk = 1'b0;
  logic        rstn;
  logic        enable;
  logic [1:0]  mode;
  logic [31:0] src;
  logic [31:0] sink;
  logic        completed;
  logic [31:0] lo;
  logic [31:0] hi;

  int n_tests = 0;
  int n_fail  = 0;
  bit chk_en  = 1'b0;

  // Reference model state: cycles remaining until the result appears.
  int          m_left = 0;
  bit          m_comp = 1'b0;
  logic [63:0] m_res  = 64'd0;
  logic [63:0] m_pend = 64'd0;

  mul_seq dut (
    .clk       (clk),
    .rstn      (rstn),
    .enable    (enable),
    .mode      (mode),
    .src       (src),
    .sink      (sink),
    .completed (completed),
    .lo        (lo),
    .hi        (hi)
  );

  always #5 clk = ~clk;

  // Product straight from the arithmetic: extend each operand per its signedness, multiply mod 2^64.
  function automatic logic [63:0] ref_product(input logic [1:0] m, input logic [31:0] a,
                                              input logic [31:0] b);
    logic [63:0] ea;
    logic [63:0] eb;
    ea = ((m == 2'b01) || (m == 2'b10)) ? {{32{a[31]}}, a} : {32'd0, a};
    eb = (m == 2'b01) ? {{32{b[31]}}, b} : {32'd0, b};
    return ea * eb;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Timing model: an accept starts a 33-edge countdown; the result lands when it expires.
  always @(posedge clk) begin
    if (!rstn) begin
      m_left = 0;
      m_comp = 1'b0;
      m_res  = 64'd0;
    end else if (m_left == 0 && enable) begin
      m_left = 33;
      m_comp = 1'b0;
      m_pend = ref_product(mode, src, sink);
    end else if (m_left > 0) begin
      m_left--;
      if (m_left == 0) begin
        m_comp = 1'b1;
        m_res  = m_pend;
      end
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      check("model_completed", {63'd0, completed}, {63'd0, m_comp});
      check("model_result", {hi, lo}, m_res);
    end
  end

  task automatic start(input logic [1:0] m, input logic [31:0] a, input logic [31:0] b);
    @(negedge clk);
    mode   = m;
    src    = a;
    sink   = b;
    enable = 1'b1;
    @(negedge clk);
    enable = 1'b0;
  endtask

  task automatic run_op(input string name, input logic [1:0] m, input logic [31:0] a,
                        input logic [31:0] b, input logic [63:0] exp);
    start(m, a, b);
    repeat (32) @(negedge clk);
    check({name, "_busy_e32"}, {63'd0, completed}, 64'd0);
    @(negedge clk);
    check({name, "_done_e33"}, {63'd0, completed}, 64'd1);
    check(name, {hi, lo}, exp);
  endtask

  initial begin
    rstn   = 1'b0;
    enable = 1'b1;
    mode   = 2'b00;
    src    = 32'd5;
    sink   = 32'd6;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk_en = 1'b1;
    check("reset_completed", {63'd0, completed}, 64'd0);
    check("reset_result", {hi, lo}, 64'd0);
    rstn   = 1'b1;
    enable = 1'b0;
    repeat (5) @(negedge clk);
    check("idle_after_reset", {63'd0, completed}, 64'd0);

    run_op("unsigned_max", 2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'hFFFF_FFFE_0000_0001);
    run_op("signed_m7x3", 2'b01, 32'hFFFF_FFF9, 32'd3, 64'hFFFF_FFFF_FFFF_FFEB);
    run_op("signed_min_sq", 2'b01, 32'h8000_0000, 32'h8000_0000, 64'h4000_0000_0000_0000);
    run_op("mixed_m1", 2'b10, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'hFFFF_FFFF_0000_0001);
    run_op("reserved_mode", 2'b11, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'hFFFF_FFFE_0000_0001);
    run_op("signed_neg_neg", 2'b01, 32'hFFFF_FFFE, 32'hFFFF_FFFD, 64'd6);
    run_op("mixed_pos_src", 2'b10, 32'd7, 32'h8000_0000, 64'h0000_0003_8000_0000);

    for (int i = 0; i < 4; i++) begin
      logic [1:0]  rm;
      logic [31:0] ra;
      logic [31:0] rb;
      rm = 2'($urandom_range(0, 3));
      ra = $urandom;
      rb = $urandom;
      start(rm, ra, rb);
      repeat (33) @(negedge clk);
    end

    // Enable pulsed mid-operation must be ignored; a held enable in DONE restarts.
    start(2'b00, 32'd5, 32'd6);
    repeat (9) @(negedge clk);
    src    = 32'd9;
    sink   = 32'd9;
    enable = 1'b1;
    @(negedge clk);
    enable = 1'b0;
    repeat (23) @(negedge clk);
    check("busy_ignore_done", {63'd0, completed}, 64'd1);
    check("busy_ignore_result", {hi, lo}, 64'd30);
    enable = 1'b1;
    @(negedge clk);
    enable = 1'b0;
    check("restart_drops_completed", {63'd0, completed}, 64'd0);
    check("restart_holds_old", {hi, lo}, 64'd30);
    repeat (32) @(negedge clk);
    check("restart_busy_e66", {63'd0, completed}, 64'd0);
    @(negedge clk);
    check("restart_done_e67", {63'd0, completed}, 64'd1);
    check("restart_result", {hi, lo}, 64'd81);

    // Reset partway through an operation aborts it with no result.
    start(2'b01, 32'hFFFF_FFF9, 32'd7);
    repeat (9) @(negedge clk);
    rstn = 1'b0;
    @(negedge clk);
    check("abort_completed", {63'd0, completed}, 64'd0);
    check("abort_result", {hi, lo}, 64'd0);
    rstn = 1'b1;
    repeat (40) @(negedge clk);
    check("abort_no_late_done", {63'd0, completed}, 64'd0);

    chk_en = 1'b0;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
